// File: rtl/pc_unit.sv
// Program counter / next-PC unit: sequential, branch, JAL, JALR, MRET, trap entry and misalignment trap.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            trap_req,
  output logic [XLEN-1:0] program_counter,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic            ras_overflow,
  output logic            ras_underflow
);
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JAL    = 3'd2;
  localparam logic [2:0] SEL_JALR   = 3'd3;
  localparam logic [2:0] SEL_MRET   = 3'd4;

  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic            ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;
  logic [XLEN-1:0] seq_tgt, rel_tgt, jalr_sum, target, ras_top;
  logic            checked, bad_target, advance, ras_pop_hit;

  assign seq_tgt  = pc_q + XLEN'(4);
  assign rel_tgt  = pc_q + imm;
  assign jalr_sum = rs1_val + imm;

  always_comb begin
    target  = seq_tgt;
    checked = 1'b0;
    case (pc_sel)
      SEL_BRANCH: begin
        if (branch_taken) begin
          target  = rel_tgt;
          checked = 1'b1;
        end
      end
      SEL_JAL: begin
        target  = rel_tgt;
        checked = 1'b1;
      end
      SEL_JALR: begin
        target  = ras_pop_hit ? ras_top : {jalr_sum[XLEN-1:1], 1'b0};
        checked = 1'b1;
      end
      SEL_MRET: target = epc_q;
      default:  target = seq_tgt;
    endcase
  end

  assign bad_target = checked && (target[1:0] != 2'b00);
  // The RAS only moves on an instruction that actually retires to its target.
  assign advance    = !trap_req && !stall && !bad_target;

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    if (trap_req) begin
      pc_d  = TRAP_VECTOR;
      epc_d = {pc_q[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      if (bad_target) begin
        pc_d         = TRAP_VECTOR;
        epc_d        = {pc_q[XLEN-1:2], 2'b00};
        misaligned_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

`ifdef PC_RAS_EN
  localparam int            PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0]   FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   sp_q, sp_d, top_idx, wr_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wr_en, call_ok, ret_ok;

  assign call_ok     = is_call && (pc_sel == SEL_JAL || pc_sel == SEL_JALR);
  assign ret_ok      = is_ret && (pc_sel == SEL_JALR);
  assign top_idx     = sp_q - PW'(1);
  assign ras_top     = ras_mem[top_idx];
  assign ras_pop_hit = ret_ok && (cnt_q != '0);

  // sp_q points at the next free slot; when full that slot is the oldest entry.
  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_idx    = sp_q;
    ras_ovf_d = 1'b0;
    ras_unf_d = 1'b0;
    if (advance) begin
      if (ret_ok) begin
        if (cnt_q == '0) begin
          ras_unf_d = 1'b1;
        end else begin
          sp_d  = top_idx;
          cnt_d = cnt_q - (PW+1)'(1);
        end
      end
      if (call_ok) begin
        wr_en  = 1'b1;
        wr_idx = sp_d;
        sp_d   = sp_d + PW'(1);
        if (cnt_d == FULL) ras_ovf_d = 1'b1;
        else               cnt_d     = cnt_d + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= seq_tgt;
  end
`else
  logic ras_unused;
  assign ras_unused  = ^{is_call, is_ret, advance};
  assign ras_pop_hit = 1'b0;
  assign ras_top     = '0;
  assign ras_ovf_d   = 1'b0;
  assign ras_unf_d   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      ras_ovf_q    <= 1'b0;
      ras_unf_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
      ras_ovf_q    <= ras_ovf_d;
      ras_unf_q    <= ras_unf_d;
    end
  end

  assign program_counter = pc_q;
  assign pc_plus4        = seq_tgt;
  assign epc             = epc_q;
  assign misaligned      = misaligned_q;
  assign ras_overflow    = ras_ovf_q;
  assign ras_underflow   = ras_unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, branch/stall, trap/MRET, misalignment, RAS (when PC_RAS_EN), async reset.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, is_call, is_ret, trap_req;
  logic [2:0]  pc_sel;
  logic [31:0] imm, rs1_val;
  logic [31:0] program_counter, pc_plus4, epc;
  logic        misaligned, ras_overflow, ras_underflow;
  int          n_tests = 0;
  int          n_fail  = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
    .branch_taken(branch_taken), .imm(imm), .rs1_val(rs1_val),
    .is_call(is_call), .is_ret(is_ret), .trap_req(trap_req),
    .program_counter(program_counter), .pc_plus4(pc_plus4), .epc(epc),
    .misaligned(misaligned), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [2:0] sel, input logic bt, input logic [31:0] im,
                     input logic [31:0] rs, input logic call, input logic ret,
                     input logic stl, input logic trp);
    pc_sel = sel; branch_taken = bt; imm = im; rs1_val = rs;
    is_call = call; is_ret = ret; stall = stl; trap_req = trp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drv(3'd0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_pc", program_counter, 32'h0);
    chk("reset_epc", epc, 32'h0);
    chk("reset_pulses", {29'd0, misaligned, ras_overflow, ras_underflow}, 32'h0);
    #9 reset = 1'b1;
    chk("pc_plus4_at_0", pc_plus4, 32'h4);
    tick(); chk("seq1", program_counter, 32'h4);
    tick(); chk("seq2", program_counter, 32'h8);
    tick(); chk("seq3", program_counter, 32'hC);
    chk("seq_epc", epc, 32'h0);
    // back to 0x8 via JALR, then branch tests
    drv(3'd3, 0, 0, 32'h8, 0, 0, 0, 0); tick(); chk("jalr_to_8", program_counter, 32'h8);
    drv(3'd1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0); tick(); chk("branch_taken", program_counter, 32'h0);
    drv(3'd3, 0, 0, 32'h8, 0, 0, 0, 0); tick();
    drv(3'd1, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0); tick(); chk("branch_not_taken", program_counter, 32'hC);
    drv(3'd0, 0, 0, 0, 0, 0, 1, 0); tick(); chk("stall1", program_counter, 32'hC);
    tick(); chk("stall2", program_counter, 32'hC);
    drv(3'd0, 0, 0, 0, 0, 0, 1, 1); tick(); chk("trap_in_stall", program_counter, 32'h100);
    chk("trap_in_stall_epc", epc, 32'hC);
    drv(3'd4, 0, 0, 0, 0, 0, 0, 0); tick(); chk("mret1", program_counter, 32'hC);
    drv(3'd0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("seq_to_10", program_counter, 32'h10);
    drv(3'd0, 0, 0, 0, 0, 0, 0, 1); tick(); chk("trap_pc", program_counter, 32'h100);
    chk("trap_epc", epc, 32'h10);
    drv(3'd4, 0, 0, 0, 0, 0, 0, 0); tick(); chk("mret2", program_counter, 32'h10);
    drv(3'd6, 0, 0, 0, 0, 0, 0, 0); tick(); chk("sel6_is_seq", program_counter, 32'h14);
    // misalignment
    drv(3'd3, 0, 0, 32'h0, 0, 0, 0, 0); tick(); chk("jalr_to_0", program_counter, 32'h0);
    drv(3'd2, 0, 32'h6, 0, 0, 0, 1, 0); tick(); chk("mis_stalled_pc", program_counter, 32'h0);
    chk("mis_stalled_pulse", {31'd0, misaligned}, 32'h0);
    drv(3'd2, 0, 32'h6, 0, 0, 0, 0, 0); tick(); chk("mis_jal_pc", program_counter, 32'h100);
    chk("mis_jal_epc", epc, 32'h0);
    chk("mis_jal_pulse", {31'd0, misaligned}, 32'h1);
    drv(3'd0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("mis_pulse_clear", {31'd0, misaligned}, 32'h0);
    chk("after_mis_seq", program_counter, 32'h104);
    drv(3'd3, 0, 0, 32'h21, 0, 0, 0, 0); tick(); chk("jalr_lsb_clear", program_counter, 32'h20);
    chk("jalr_lsb_no_pulse", {31'd0, misaligned}, 32'h0);
    drv(3'd3, 0, 0, 32'h22, 0, 0, 0, 0); tick(); chk("jalr_mis_pc", program_counter, 32'h100);
    chk("jalr_mis_epc", epc, 32'h20);
    chk("jalr_mis_pulse", {31'd0, misaligned}, 32'h1);
    drv(3'd1, 1, 32'h2, 0, 0, 0, 0, 0); tick(); chk("br_mis_pc", program_counter, 32'h100);
    chk("br_mis_epc", epc, 32'h100);
`ifdef PC_RAS_EN
    drv(3'd3, 0, 0, 32'h0, 0, 0, 0, 0); tick();
    drv(3'd2, 0, 32'h40, 0, 1, 0, 0, 0);
    tick(); chk("call1", program_counter, 32'h40);
    tick(); chk("call2", program_counter, 32'h80);
    tick(); chk("call3", program_counter, 32'hC0);
    tick(); chk("call4", program_counter, 32'h100);
    chk("call4_no_ovf", {31'd0, ras_overflow}, 32'h0);
    tick(); chk("call5", program_counter, 32'h140);
    chk("call5_ovf", {31'd0, ras_overflow}, 32'h1);
    drv(3'd3, 0, 0, 32'h200, 0, 1, 0, 0);
    tick(); chk("ret1", program_counter, 32'h104);
    chk("ret1_ovf_clear", {31'd0, ras_overflow}, 32'h0);
    tick(); chk("ret2", program_counter, 32'hC4);
    tick(); chk("ret3", program_counter, 32'h84);
    tick(); chk("ret4", program_counter, 32'h44);
    chk("ret4_no_unf", {31'd0, ras_underflow}, 32'h0);
    tick(); chk("ret5_rs1", program_counter, 32'h200);
    chk("ret5_unf", {31'd0, ras_underflow}, 32'h1);
    drv(3'd3, 0, 0, 32'h300, 1, 1, 0, 0); tick(); chk("callret_empty_pc", program_counter, 32'h300);
    chk("callret_empty_unf", {31'd0, ras_underflow}, 32'h1);
    drv(3'd3, 0, 0, 32'h400, 0, 1, 0, 0); tick(); chk("ret_after_callret", program_counter, 32'h204);
    chk("ret_after_callret_unf", {31'd0, ras_underflow}, 32'h0);
`else
    drv(3'd3, 0, 0, 32'h40, 1, 1, 0, 0); tick(); chk("noras_jalr_ret", program_counter, 32'h40);
    chk("noras_pulses", {30'd0, ras_overflow, ras_underflow}, 32'h0);
    drv(3'd3, 0, 0, 32'h80, 0, 1, 0, 0); tick(); chk("noras_ret_rs1", program_counter, 32'h80);
    chk("noras_unf", {31'd0, ras_underflow}, 32'h0);
`endif
    // async reset during a trap
    drv(3'd3, 0, 0, 32'h40, 0, 0, 0, 0); tick();
    drv(3'd0, 0, 0, 0, 0, 0, 0, 1); tick(); chk("pre_rst_trap_pc", program_counter, 32'h100);
    chk("pre_rst_trap_epc", epc, 32'h40);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pc", program_counter, 32'h0);
    chk("async_rst_epc", epc, 32'h0);
    tick(); chk("rst_held_pc", program_counter, 32'h0);
    #3 reset = 1'b1;
    drv(3'd0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("post_rst_seq", program_counter, 32'h4);
`ifdef PC_RAS_EN
    drv(3'd3, 0, 0, 32'h500, 0, 1, 0, 0); tick(); chk("post_rst_ras_empty_pc", program_counter, 32'h500);
    chk("post_rst_ras_empty_unf", {31'd0, ras_underflow}, 32'h1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
